// File: rtl/rv32_pkg.sv
// Shared RV32 constants for the register file slice.
// Defaults for data width, register count and the x0 index.
package rv32_pkg;

    localparam int RV_XLEN = 32;
    localparam int RV_NREG = 32;
    localparam int X0_IDX  = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: set on issue, clear on write.
// Issue beats write-back to the same register in one cycle.
module regfile_scoreboard
    import rv32_pkg::*;
#(
    parameter int DEPTH    = RV_NREG,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic [DEPTH-1:0]    busy_vec
);

    logic [DEPTH-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy_vec;
        for (int j = 0; j < NWR; j++) begin
            if (we[j]) busy_nxt[wa[j*AW +: AW]] = 1'b0;
        end
        if (iss_valid) busy_nxt[iss_rd] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[X0_IDX] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy_vec <= '0;
        else        busy_vec <= busy_nxt;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with scoreboard, combinational reads.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp
    import rv32_pkg::*;
#(
    parameter int XLEN     = RV_XLEN,
    parameter int DEPTH    = RV_NREG,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic [DEPTH-1:0]    busy_vec
);

    localparam logic [AW-1:0] ZADDR = AW'(X0_IDX);

    logic [XLEN-1:0] regs [DEPTH];

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == ZADDR);
    endfunction

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .wa        (wa),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy_vec  (busy_vec)
    );

    // Later ports are assigned last, so the highest index wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && !is_zero(wa[j*AW +: AW]))
                    regs[wa[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] d;
            logic            b;
            a = ra[k*AW +: AW];
            d = regs[a];
            b = busy_vec[a];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] == a)) begin
                    d = wdata[j*XLEN +: XLEN];
                    b = iss_valid && (iss_rd == a);
                end
            end
`endif
            if (is_zero(a)) begin
                d = '0;
                b = 1'b0;
            end
            rdata[k*XLEN +: XLEN] = d;
            rbusy[k] = b;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (NRD=2, NWR=2).
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int DEPTH = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wdata;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic [DEPTH-1:0]    busy_vec;

    int n_chk = 0;
    int n_pass = 0;

    regfile_mp #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra        (ra),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .we        (we),
        .wa        (wa),
        .wdata     (wdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy_vec  (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0;
        wa = '0;
        wdata = '0;
        iss_valid = 1'b0;
        iss_rd = '0;
    endtask

    function automatic logic [31:0] rd0();
        return rdata[31:0];
    endfunction

    function automatic logic [31:0] rd1();
        return rdata[63:32];
    endfunction

    initial begin
        idle();
        ra = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        ra[0 +: AW] = 5'd5;
        ra[AW +: AW] = 5'd3;
        #1;
        chk("rst_rdata0", 64'(rd0()), 64'h0);
        chk("rst_busy", 64'(busy_vec), 64'h0);
        chk("rst_rbusy", 64'(rbusy), 64'h0);

        we = 2'b01;
        wa[0 +: AW] = 5'd5;
        wdata[0 +: XLEN] = 32'hDEADBEEF;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x5_same_cyc", 64'(rd0()), 64'hDEADBEEF);
`else
        chk("x5_before", 64'(rd0()), 64'h0);
`endif
        step();
        idle();
        #1;
        chk("x5_after", 64'(rd0()), 64'hDEADBEEF);

        we = 2'b11;
        wa = {5'd7, 5'd7};
        wdata = {32'h22, 32'h11};
        step();
        idle();
        ra[0 +: AW] = 5'd7;
        #1;
        chk("x7_port1_wins", 64'(rd0()), 64'h22);
        chk("x7_not_busy", 64'(busy_vec), 64'h0);

        we = 2'b01;
        wa[0 +: AW] = 5'd0;
        wdata[0 +: XLEN] = 32'hFFFFFFFF;
        iss_valid = 1'b1;
        iss_rd = 5'd0;
        ra[0 +: AW] = 5'd0;
        step();
        idle();
        #1;
        chk("x0_rdata", 64'(rd0()), 64'h0);
        chk("x0_busy", 64'(busy_vec[0]), 64'h0);
        chk("x0_rbusy", 64'(rbusy[0]), 64'h0);

        iss_valid = 1'b1;
        iss_rd = 5'd3;
        step();
        idle();
        #1;
        chk("x3_rbusy_c1", 64'(rbusy[1]), 64'h1);
        chk("x3_busyvec", 64'(busy_vec), 64'h8);
        step();
        chk("x3_rbusy_c2", 64'(rbusy[1]), 64'h1);
        we = 2'b01;
        wa[0 +: AW] = 5'd3;
        wdata[0 +: XLEN] = 32'h33;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x3_wr_cyc", 64'(rbusy[1]), 64'h0);
`else
        chk("x3_wr_cyc", 64'(rbusy[1]), 64'h1);
`endif
        step();
        idle();
        #1;
        chk("x3_cleared", 64'(rbusy[1]), 64'h0);
        chk("x3_data", 64'(rd1()), 64'h33);

        we = 2'b01;
        wa[0 +: AW] = 5'd3;
        wdata[0 +: XLEN] = 32'h44;
        iss_valid = 1'b1;
        iss_rd = 5'd3;
        step();
        idle();
        #1;
        chk("x3_set_wins", 64'(rbusy[1]), 64'h1);
        chk("x3_data_kept", 64'(rd1()), 64'h44);

        we = 2'b10;
        wa[AW +: AW] = 5'd3;
        wdata[XLEN +: XLEN] = 32'h55;
        step();
        idle();
        #1;
        chk("x3_clr_p1", 64'(busy_vec), 64'h0);
        chk("x3_data_p1", 64'(rd1()), 64'h55);

`ifdef REGFILE_BYPASS_EN
        ra[AW +: AW] = 5'd9;
        we = 2'b01;
        wa[0 +: AW] = 5'd9;
        wdata[0 +: XLEN] = 32'h1234;
        #1;
        chk("x9_bypass", 64'(rd1()), 64'h1234);
        chk("x9_byp_rbusy", 64'(rbusy[1]), 64'h0);
        step();
        idle();
`endif

        we = 2'b01;
        wa[0 +: AW] = 5'd4;
        wdata[0 +: XLEN] = 32'hAA;
        iss_valid = 1'b1;
        iss_rd = 5'd6;
        step();
        idle();
        ra[0 +: AW] = 5'd4;
        ra[AW +: AW] = 5'd5;
        #1;
        chk("x4_pre_rst", 64'(rd0()), 64'hAA);
        chk("x6_pre_rst", 64'(busy_vec), 64'h40);

        rst_n = 1'b0;
        we = 2'b01;
        wa[0 +: AW] = 5'd4;
        wdata[0 +: XLEN] = 32'h99;
        iss_valid = 1'b1;
        iss_rd = 5'd4;
        step();
        rst_n = 1'b1;
        idle();
        #1;
        chk("rst_x4", 64'(rd0()), 64'h0);
        chk("rst_x5", 64'(rd1()), 64'h0);
        chk("rst_busyvec", 64'(busy_vec), 64'h0);
        chk("rst_rbusy2", 64'(rbusy), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
